// File: rtl/fft_pkg.sv
// fft_pkg: shared frame geometry defaults and sequencer state type
package fft_pkg;

    localparam int D_WIDTH     = 64;
    localparam int LOG_2_WIDTH = 6;
    localparam int WAIT_CYCLES = 192;

    typedef enum logic [2:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_UNLOAD
    } state_t;

endpackage

// File: rtl/fft_frame_sequencer_bitrev_index.sv
// bitrev_index: mirrors the bit order of a frame index to form the load address
module bitrev_index #(
    parameter int LOG_2_WIDTH = 6
) (
    input  logic [LOG_2_WIDTH-1:0] i_idx,
    output logic [LOG_2_WIDTH-1:0] o_idx
);

    for (genvar g = 0; g < LOG_2_WIDTH; g++) begin : g_rev
        assign o_idx[g] = i_idx[LOG_2_WIDTH-1-g];
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer: loads a bit-reversed frame, runs the butterfly core, streams the result
module fft_frame_sequencer #(
    parameter int D_WIDTH     = fft_pkg::D_WIDTH,
    parameter int LOG_2_WIDTH = fft_pkg::LOG_2_WIDTH,
    parameter int WAIT_CYCLES = fft_pkg::WAIT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [15:0]              in_re,
    input  logic [15:0]              in_im,
    output logic                     core_start,
    output logic [D_WIDTH-1:0][15:0] core_in_re,
    output logic [D_WIDTH-1:0][15:0] core_in_im,
    input  logic [D_WIDTH-1:0][15:0] core_out_re,
    input  logic [D_WIDTH-1:0][15:0] core_out_im,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [15:0]              out_re,
    output logic [15:0]              out_im,
    output logic                     out_last,
    output logic                     busy
);

    import fft_pkg::*;

    localparam int WW = $clog2(WAIT_CYCLES) + 1;
    localparam logic [LOG_2_WIDTH-1:0] LAST_IDX = LOG_2_WIDTH'(D_WIDTH - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);

    state_t                     r_state;
    state_t                     w_next;
    logic [LOG_2_WIDTH-1:0]     r_load_cnt;
    logic [LOG_2_WIDTH-1:0]     r_out_idx;
    logic [LOG_2_WIDTH-1:0]     w_wr_addr;
    logic [WW-1:0]              r_wait_cnt;
    logic [D_WIDTH-1:0][15:0]   r_buf_re;
    logic [D_WIDTH-1:0][15:0]   r_buf_im;
    logic                       w_load_fire;
    logic                       w_out_fire;

    bitrev_index #(.LOG_2_WIDTH(LOG_2_WIDTH)) u_bitrev (
        .i_idx(r_load_cnt),
        .o_idx(w_wr_addr)
    );

    assign in_ready    = (r_state == S_LOAD);
    assign core_start  = (r_state == S_START);
    assign out_valid   = (r_state == S_UNLOAD);
    assign busy        = (r_state != S_LOAD);
    assign w_load_fire = in_valid & in_ready;
    assign w_out_fire  = out_valid & out_ready;
    assign out_last    = out_valid & (r_out_idx == LAST_IDX);
    assign out_re      = out_valid ? r_buf_re[r_out_idx] : '0;
    assign out_im      = out_valid ? r_buf_im[r_out_idx] : '0;
    assign core_in_re  = r_buf_re;
    assign core_in_im  = r_buf_im;

    // Next-state selection for the frame lifecycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:    w_next = (w_load_fire && r_load_cnt == LAST_IDX) ? S_START : S_LOAD;
            S_START:   w_next = S_WAIT;
            S_WAIT:    w_next = (r_wait_cnt == WAIT_LAST) ? S_CAPTURE : S_WAIT;
            S_CAPTURE: w_next = S_UNLOAD;
            S_UNLOAD:  w_next = (w_out_fire && r_out_idx == LAST_IDX) ? S_LOAD : S_UNLOAD;
            default:   w_next = S_LOAD;
        endcase
    end

    // State register, clocked on the falling edge like the butterfly core
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) r_state <= S_LOAD;
        else      r_state <= w_next;
    end

    // Load, wait and unload counters; power-of-two widths give free wraparound
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_load_cnt <= '0;
            r_out_idx  <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_load_cnt <= r_load_cnt + LOG_2_WIDTH'(w_load_fire);
            r_out_idx  <= r_out_idx + LOG_2_WIDTH'(w_out_fire);
            r_wait_cnt <= (r_state == S_START) ? '0 :
                          (r_state == S_WAIT)  ? r_wait_cnt + 1'b1 : r_wait_cnt;
        end
    end

    // Frame buffer: bit-reversed sample writes during load, whole-frame capture of the core result
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_re <= '0;
            r_buf_im <= '0;
        end else if (r_state == S_CAPTURE) begin
            r_buf_re <= core_out_re;
            r_buf_im <= core_out_im;
        end else if (w_load_fire) begin
            r_buf_re[w_wr_addr] <= in_re;
            r_buf_im[w_wr_addr] <= in_im;
        end
    end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// tb_fft_frame_sequencer: randomized frame traffic checked against a reference model of the sequencer
module tb_fft_frame_sequencer;

    localparam int D  = 64;
    localparam int L  = 6;
    localparam int WC = 192;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [15:0]       in_re = '0;
    logic [15:0]       in_im = '0;
    logic              in_ready, core_start, out_valid, out_last, busy;
    logic [15:0]       out_re, out_im;
    logic [D-1:0][15:0] core_in_re, core_in_im;
    logic [D-1:0][15:0] core_out_re = '0;
    logic [D-1:0][15:0] core_out_im = '0;

    logic [15:0] fr_re [D];
    logic [15:0] fr_im [D];
    logic [15:0] cr_re [D];
    logic [15:0] cr_im [D];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fft_frame_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .core_start(core_start), .core_in_re(core_in_re), .core_in_im(core_in_im),
        .core_out_re(core_out_re), .core_out_im(core_out_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_last(out_last), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int rev(input int n);
        int r = 0;
        for (int b = 0; b < L; b++) if ((n >> b) & 1) r += 1 << (L - 1 - b);
        return r;
    endfunction

    task automatic make_frame(input bit ramp);
        for (int i = 0; i < D; i++) begin
            fr_re[i] = ramp ? 16'(i) : 16'($urandom);
            fr_im[i] = ramp ? 16'h0 : 16'($urandom);
            cr_re[i] = ramp ? 16'(1000 + i) : 16'($urandom);
            cr_im[i] = 16'($urandom);
        end
    endtask

    // Called right after a posedge while the sequencer is loading
    task automatic load(input int cnt, input bit gaps);
        int n = 0;
        int guard = 0;
        while (n < cnt && guard < 1000) begin
            check("load_in_ready", 32'(in_ready), 32'd1);
            check("load_busy", 32'(busy), 32'd0);
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_re = fr_re[n];
            in_im = fr_im[n];
            @(posedge clk);
            if (in_valid) n++;
            guard++;
        end
        in_valid = 1'b0;
        if (n < cnt) check("load_timeout", 32'(n), 32'(cnt));
    endtask

    // Called at the posedge that follows the final accept
    task automatic process(input int hold_at, input bit junk, input bit full_rate);
        int cyc = 0;
        int k = 0;
        int held = 0;
        int guard = 0;
        bit rdy;
        check("start_pulse", 32'(core_start), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < D; i++)
            check($sformatf("core_in[%0d]", rev(i)), {core_in_re[rev(i)], core_in_im[rev(i)]}, {fr_re[i], fr_im[i]});
        for (int i = 0; i < D; i++) begin
            core_out_re[i] = cr_re[i];
            core_out_im[i] = cr_im[i];
        end
        in_valid = junk;
        in_re = 16'hDEAD;
        in_im = 16'hDEAD;
        do begin
            @(posedge clk);
            cyc++;
            check("start_one_cycle", 32'(core_start), 32'd0);
            if (!out_valid) begin
                check("wait_in_ready", 32'(in_ready), 32'd0);
                check("wait_core_in_stable", {core_in_re[rev(cyc % D)], core_in_im[rev(cyc % D)]},
                      {fr_re[cyc % D], fr_im[cyc % D]});
            end
        end while (!out_valid && cyc < 1000);
        // WAIT_CYCLES wait cycles, one capture cycle, then the first unload cycle is observed
        check("wait_latency", 32'(cyc), 32'(WC + 2));
        while (k < D && guard < 2000) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check($sformatf("out_re[%0d]", k), 32'(out_re), 32'(cr_re[k]));
            check($sformatf("out_im[%0d]", k), 32'(out_im), 32'(cr_im[k]));
            check($sformatf("out_last[%0d]", k), 32'(out_last), 32'(k == D - 1));
            check("unload_in_ready", 32'(in_ready), 32'd0);
            if (k == hold_at && held < 5) begin
                rdy = 1'b0;
                held++;
            end else begin
                rdy = full_rate ? 1'b1 : ($urandom_range(0, 3) != 0);
            end
            out_ready = rdy;
            @(posedge clk);
            if (rdy) k++;
            guard++;
        end
        if (k < D) check("unload_timeout", 32'(k), 32'(D));
        out_ready = full_rate;
        in_valid = 1'b0;
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_busy", 32'(busy), 32'd0);
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_out_last", 32'(out_last), 32'd0);
    endtask

    task automatic frame(input bit ramp, input bit gaps, input int hold_at, input bit junk, input bit full_rate);
        make_frame(ramp);
        load(D, gaps);
        process(hold_at, junk, full_rate);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", {out_re, out_im}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        frame(1'b1, 1'b0, 10, 1'b1, 1'b0);
        frame(1'b0, 1'b1, 10, 1'b1, 1'b0);
        frame(1'b0, 1'b0, -1, 1'b0, 1'b1);
        frame(1'b0, 1'b0, -1, 1'b0, 1'b1);
        make_frame(1'b0);
        load(20, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_core_start", 32'(core_start), 32'd0);
        for (int i = 0; i < D; i++)
            check("midrst_buffer_zero", {core_in_re[i], core_in_im[i]}, 32'd0);
        @(posedge clk);
        rst = 1'b1;
        @(posedge clk);
        frame(1'b0, 1'b1, $urandom_range(0, D - 1), 1'b1, 1'b0);
        frame(1'b0, 1'b1, D - 1, 1'b0, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 SHALL have parameter D_WIDTH, default 64, points per frame.
REQ-002 SHALL have parameter LOG_2_WIDTH, default 6, log2(D_WIDTH).
REQ-003 SHALL have parameter WAIT_CYCLES, default 192, clk cycles from core_start deassertion to result capture.
REQ-004 SHALL have port clk  input  1  clock; all state updates on falling edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  upstream sample valid.
REQ-007 SHALL have port in_ready  output  1  sequencer accepts sample.
REQ-008 SHALL have port in_re / in_im  input  16 each  sample real/imag.
REQ-009 SHALL have port core_start  output  1  one-cycle start pulse to butterfly core.
REQ-010 SHALL have port core_in_re / core_in_im  output  D_WIDTH x 16  bit-reversed frame to core inputs.
REQ-011 SHALL have port core_out_re / core_out_im  input  D_WIDTH x 16  core result array.
REQ-012 SHALL have port out_valid  input-side handshake: output  1  result sample valid.
REQ-013 SHALL have port out_ready  input  1  downstream accepts sample.
REQ-014 SHALL have port out_re / out_im  output  16 each  result sample.
REQ-015 SHALL have port out_last  output  1  high with index D_WIDTH-1 result.
REQ-016 SHALL have port busy  output  1  high in any state except LOAD.

Function
REQ-017 SHALL implement states LOAD, START, WAIT, CAPTURE, UNLOAD.
REQ-018 LOAD: in_ready=1; on in_valid, sample n (n = load count 0..D_WIDTH-1) SHALL be written to buffer[bitrev(n)] over LOG_2_WIDTH bits; count increments.
REQ-019 LOAD -> START on the edge accepting sample D_WIDTH-1; load count wraps to 0.
REQ-020 START: core_start=1 for exactly one cycle; next state WAIT; wait counter cleared.
REQ-021 WAIT: counter increments per cycle; -> CAPTURE when counter reaches WAIT_CYCLES-1.
REQ-022 CAPTURE: core_out_re/im latched into the frame buffer in one cycle; -> UNLOAD.
REQ-023 UNLOAD: out_valid=1; out_re/im = buffer[k], k natural order 0..D_WIDTH-1; k advances only when out_valid & out_ready.
REQ-024 out_last SHALL equal out_valid & (k == D_WIDTH-1); acceptance of that sample -> LOAD, k wraps to 0.
REQ-025 Under out_ready=0, out_re/im/out_last SHALL hold stable.
REQ-026 in_ready SHALL be 0 outside LOAD; in_valid then SHALL be ignored and no buffer write occurs.
REQ-027 core_in_re/im SHALL be driven continuously from the buffer; stable from START through WAIT.
REQ-028 Data passes unmodified; no arithmetic on sample values; counters LOG_2_WIDTH bits, wait counter ceil(log2(WAIT_CYCLES))+1 bits.

Reset
REQ-029 rst low SHALL immediately force state LOAD, all counters 0, buffer all zero.
REQ-030 Reset values: in_ready=1 after release, core_start=0, out_valid=0, out_last=0, busy=0, out_re/im=0.
REQ-031 Reset mid-frame in any state SHALL discard the partial frame; first post-reset sample is index 0.

Structure
REQ-032 Package fft_pkg SHALL hold D_WIDTH, LOG_2_WIDTH defaults and the state enum type.
REQ-033 Sub-module bitrev_index (combinational, parameter LOG_2_WIDTH) SHALL compute the write address.
REQ-034 Single clock domain, falling-edge registers, matching the butterfly core.

Verification
REQ-035 Load in_re=n, in_im=0 for n=0..63 -> core_in_re[1]=32, core_in_re[32]=1, core_in_re[63]=63; core_start one cycle after 64th accept.
REQ-036 Count cycles from core_start fall to CAPTURE -> exactly 192; core_out_re[k]=1000+k then streamed as 1000..1063 with out_last only on 1063.
REQ-037 Hold out_ready=0 for 5 cycles at k=10 -> out_re stays 1010, k unchanged, no sample lost.
REQ-038 Assert in_valid during WAIT/UNLOAD with in_re=16'hDEAD -> in_ready=0, buffer and output unchanged.
REQ-039 Pull rst low after 20 samples loaded -> busy=0, counters 0, next frame sample 0 lands at buffer[0].
REQ-040 Back-to-back frames with out_ready=1 constant -> second frame accepted from cycle after first out_last; both outputs correct.
